// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder.
// Holds the FSM state encoding plus the slice-count and counter-width math.
package chunked_adder_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // A single-slice configuration still needs a one-bit counter.
  function automatic int cnt_width(input int slices);
    return (clog2(slices) > 0) ? clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_chunk.sv
// Combinational CHUNK-bit ripple adder assembled from 1-bit full-adder cells.
// The carry chain length is bounded by the slice width, not the operand width.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
);

  logic [W:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (carry[i]),
      .s    (s[i]),
      .c_out(carry[i+1])
    );
  end

  assign c_out = carry[W];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit slice per clock, LSB first,
// with the inter-slice carry registered and NZCV flags loaded with the result.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             n,
  output logic             z,
  output logic             v
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_width(NCHUNK);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $fatal(1, "chunked_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;
  logic [CHUNK-1:0] slice_s;
  logic             slice_c;
  logic             last;

  // Operands shift right each cycle so the active slice always sits in the low bits.
  adder_chunk #(
    .W(CHUNK)
  ) u_chunk (
    .a    (a_reg[CHUNK-1:0]),
    .b    (b_reg[CHUNK-1:0]),
    .c_in (carry),
    .s    (slice_s),
    .c_out(slice_c)
  );

  // The slice sum enters at the top so the result is LSB-aligned after the last slice.
  always_comb begin
    acc_next = (acc >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
    last     = (cnt == CNT_W'(NCHUNK - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
      n     <= 1'b0;
      z     <= 1'b1;
      v     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            carry <= sub ? 1'b1 : c_in;
            cnt   <= '0;
            acc   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> CHUNK;
          b_reg <= b_reg >> CHUNK;
          acc   <= acc_next;
          carry <= slice_c;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            s     <= acc_next;
            c_out <= slice_c;
            n     <= acc_next[WIDTH-1];
            z     <= (acc_next == '0);
            v     <= (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
            carry <= 1'b0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
